leaf_refill_arbiter: RTL
========================

# leaf_refill_arbiter

Round-robin scheduler that shares the single external-memory read port among the `NUM_LEAVES` leaf input FIFOs of the merge tree. It issues fixed-length burst refill requests for leaves whose FIFOs run low, and tracks one outstanding burst per leaf with a global outstanding-burst cap. It raises `o_finished` once every leaf's run has been fully fetched and all bursts have returned. It sits between the leaf FIFOs and the memory reader, upstream of the merger control cells.

## Interface
- `NUM_LEAVES`, 8: number of leaf FIFOs (power of two, ≥2).
- `LEAF_W`, 3: log2(`NUM_LEAVES`).
- `BURST_LEN`, 16: tuples per refill burst.
- `LEN_W`, 8: width of the burst-length field.
- `MAX_OUTSTANDING`, 4: cap on in-flight bursts (1..`NUM_LEAVES`).
- `i_clk`, in, 1: clock; all state updates on its rising edge.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_leaf_low`, in, `NUM_LEAVES`: FIFO i is below its refill threshold.
- `i_leaf_empty`, in, `NUM_LEAVES`: FIFO i is completely empty (urgent).
- `i_leaf_exhausted`, in, `NUM_LEAVES`: the run for leaf i is fully fetched; never request it again.
- `o_req_valid`, out, 1: a burst request is presented.
- `o_req_leaf`, out, `LEAF_W`: leaf index of the request.
- `o_req_len`, out, `LEN_W`: always `BURST_LEN`.
- `i_req_ready`, in, 1: memory reader accepts the request.
- `i_resp_valid`, in, 1: a response beat is present.
- `i_resp_leaf`, in, `LEAF_W`: leaf the beat belongs to.
- `i_resp_last`, in, 1: final beat of that leaf's burst.
- `o_pending`, out, `NUM_LEAVES`: leaf i has a burst in flight.
- `o_finished`, out, 1: all leaves exhausted and nothing in flight; sticky.

## Operation
- Eligibility: leaf i is eligible when `i_leaf_low[i]` is set, `i_leaf_exhausted[i]` is clear, and `pending[i]` is clear.
- FSM states: IDLE, ISSUE, FINISHED.
- IDLE → ISSUE when any leaf is eligible and `outstanding` < `MAX_OUTSTANDING`.
  - On this transition, register the winner as the first eligible leaf at or after `rr_ptr`, wrapping modulo `NUM_LEAVES`.
- IDLE → FINISHED when `i_leaf_exhausted` is all-ones and `outstanding` == 0.
  - This check takes priority over issuing.
- ISSUE: `o_req_valid` is 1, and `o_req_leaf` is held stable until `i_req_ready` is sampled high.
  - The request is never withdrawn, even if the leaf becomes exhausted or no longer low.
- On the request handshake:
  - set `pending[leaf]`;
  - increment `outstanding`;
  - set `rr_ptr` = (leaf+1) mod `NUM_LEAVES`;
  - go to IDLE.
- On `i_resp_valid & i_resp_last` for a pending leaf: clear `pending[leaf]` and decrement `outstanding`.
  - A response for a non-pending leaf is ignored.
  - Non-last beats are ignored.
- A handshake and a `resp_last` in the same cycle leave `outstanding` unchanged (+1−1).
  - Both `pending` updates still apply.
- FINISHED is absorbing until `i_rst`; `o_req_valid` stays 0.
- `outstanding` is a counter of width clog2(`MAX_OUTSTANDING`+1). It never exceeds `MAX_OUTSTANDING` and never underflows.

## Timing
- Reset values (one cycle after `i_rst` is sampled high):
  - state = IDLE, `rr_ptr` = 0, `outstanding` = 0;
  - `o_pending` = 0, `o_req_valid` = 0, `o_req_leaf` = 0, `o_finished` = 0.
- Reset mid-operation: any in-flight request is dropped on the next cycle.
  - Later responses are ignored because `pending` is clear.
- Request latency:
  - eligibility visible in cycle t → `o_req_valid` = 1 in cycle t+1;
  - handshake in cycle t → earliest next request in cycle t+2 (one request per 2 cycles maximum).
- `o_pending` reflects a handshake one cycle after it; it clears one cycle after `resp_last`.
- `o_finished` rises one cycle after the terminating condition is seen in IDLE.
- The cap is reached when `outstanding` == `MAX_OUTSTANDING`: the FSM stays in IDLE until a `resp_last` arrives.

## Configuration
- `REFILL_URGENT_EN` defined:
  - eligible leaves with `i_leaf_empty` set form an urgent class and win over low-only leaves;
  - round-robin from `rr_ptr` applies within the winning class;
  - `rr_ptr` update rule is unchanged.
- Undefined: `i_leaf_empty` is ignored (port kept), and arbitration is single-class round-robin.

## Structure
- Package `refill_pkg` holds:
  - the state enum (IDLE, ISSUE, FINISHED);
  - the default parameter constants;
  - a `clog2` helper function.
- Sub-module `rr_picker`: combinational find-first-set on a request mask starting at a pointer, with wrap.
  - Outputs are `found` and `index`.
  - Instantiate it once, or twice under `REFILL_URGENT_EN` (urgent and normal classes).

## Test plan
- Reset, then `i_leaf_low` = 8'b0000_0101 with `i_req_ready` = 1:
  - requests for leaf 0, then leaf 2, spaced 2 cycles apart, each with `o_req_len` = 16;
  - `o_pending` = 8'b0000_0101; no further requests.
- All 8 leaves low, `i_req_ready` = 1, no responses:
  - exactly 4 requests (leaves 0, 1, 2, 3), then idle;
  - one `resp_last` for leaf 1 → next request is for leaf 4.
- `i_req_ready` held 0 for 5 cycles during ISSUE while `i_leaf_exhausted[leaf]` rises:
  - `o_req_valid`/`o_req_leaf` stay stable and the request completes on ready.
- Same-cycle handshake for leaf 5 and `resp_last` for leaf 3 with `outstanding` = 2:
  - `outstanding` remains 2, `pending[5]` = 1, `pending[3]` = 0.
- All leaves exhausted with one burst in flight:
  - `o_finished` stays 0 until `resp_last`, rises 1 cycle later, and stays high;
  - `i_rst` clears it.
- With `REFILL_URGENT_EN`, `rr_ptr` = 0, leaves 1 and 6 low, only leaf 6 empty:
  - leaf 6 is granted first;
  - without the macro, leaf 1 is granted first.

Source files
------------

// File: rtl/refill_pkg.sv
// Shared types and defaults for the leaf refill arbiter: FSM state encoding,
// default geometry constants and a constant-foldable clog2 helper.
package refill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_FINISHED = 2'd2
  } state_t;

  localparam int unsigned DEF_NUM_LEAVES      = 8;
  localparam int unsigned DEF_LEAF_W          = 3;
  localparam int unsigned DEF_BURST_LEN       = 16;
  localparam int unsigned DEF_LEN_W           = 8;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin find-first-set: first set bit of i_mask at or
// after i_ptr, wrapping modulo N (N must be 2**W).
module rr_picker
  import refill_pkg::*;
#(
  parameter int unsigned N = DEF_NUM_LEAVES,
  parameter int unsigned W = DEF_LEAF_W
) (
  input  logic [N-1:0] i_mask,
  input  logic [W-1:0] i_ptr,
  output logic         o_found,
  output logic [W-1:0] o_index
);

  logic [W-1:0] w_idx;

  // Scan farthest offset first so the nearest hit is the last one written.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_idx   = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      w_idx = i_ptr + W'(k);
      if (i_mask[w_idx]) begin
        o_found = 1'b1;
        o_index = w_idx;
      end
    end
  end

endmodule

// File: rtl/leaf_refill_arbiter.sv
// Round-robin burst refill scheduler for the merge-tree leaf FIFOs.
// Optional urgent class for empty FIFOs: define REFILL_URGENT_EN.
module leaf_refill_arbiter
  import refill_pkg::*;
#(
  parameter int unsigned NUM_LEAVES      = DEF_NUM_LEAVES,
  parameter int unsigned LEAF_W          = DEF_LEAF_W,
  parameter int unsigned BURST_LEN       = DEF_BURST_LEN,
  parameter int unsigned LEN_W           = DEF_LEN_W,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_LEAVES-1:0] i_leaf_low,
  input  logic [NUM_LEAVES-1:0] i_leaf_empty,
  input  logic [NUM_LEAVES-1:0] i_leaf_exhausted,
  output logic                  o_req_valid,
  output logic [LEAF_W-1:0]     o_req_leaf,
  output logic [LEN_W-1:0]      o_req_len,
  input  logic                  i_req_ready,
  input  logic                  i_resp_valid,
  input  logic [LEAF_W-1:0]     i_resp_leaf,
  input  logic                  i_resp_last,
  output logic [NUM_LEAVES-1:0] o_pending,
  output logic                  o_finished
);

  localparam int unsigned CNT_W = clog2(MAX_OUTSTANDING + 1);

  state_t                r_state, w_state_nxt;
  logic [NUM_LEAVES-1:0] r_pending, w_pending_nxt;
  logic [CNT_W-1:0]      r_outstanding, w_outstanding_nxt;
  logic [LEAF_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic [LEAF_W-1:0]     r_req_leaf, w_req_leaf_nxt;
  logic                  r_req_valid, w_req_valid_nxt;
  logic                  r_finished, w_finished_nxt;

  logic [NUM_LEAVES-1:0] w_elig;
  logic                  w_win_found;
  logic [LEAF_W-1:0]     w_win_idx;
  logic                  w_hs;
  logic                  w_resp_hit;
  logic                  w_cap_ok;
  logic                  w_done;

  assign w_elig = i_leaf_low & ~i_leaf_exhausted & ~r_pending;

`ifdef REFILL_URGENT_EN
  logic                  w_urg_found, w_norm_found;
  logic [LEAF_W-1:0]     w_urg_idx, w_norm_idx;

  rr_picker #(.N(NUM_LEAVES), .W(LEAF_W)) u_pick_urgent (
    .i_mask  (w_elig & i_leaf_empty),
    .i_ptr   (r_rr_ptr),
    .o_found (w_urg_found),
    .o_index (w_urg_idx)
  );

  rr_picker #(.N(NUM_LEAVES), .W(LEAF_W)) u_pick_normal (
    .i_mask  (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_found (w_norm_found),
    .o_index (w_norm_idx)
  );

  // Any empty eligible leaf preempts the low-only leaves.
  assign w_win_found = w_urg_found | w_norm_found;
  assign w_win_idx   = w_urg_found ? w_urg_idx : w_norm_idx;
`else
  logic w_unused_empty;
  assign w_unused_empty = ^i_leaf_empty;

  rr_picker #(.N(NUM_LEAVES), .W(LEAF_W)) u_pick (
    .i_mask  (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_found (w_win_found),
    .o_index (w_win_idx)
  );
`endif

  assign w_hs       = (r_state == ST_ISSUE) & i_req_ready;
  assign w_resp_hit = i_resp_valid & i_resp_last & r_pending[i_resp_leaf];
  assign w_cap_ok   = r_outstanding < CNT_W'(MAX_OUTSTANDING);
  assign w_done     = (&i_leaf_exhausted) & (r_outstanding == '0);

  // Next-state, bookkeeping and registered-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_pending_nxt     = r_pending;
    w_outstanding_nxt = r_outstanding;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_req_leaf_nxt    = r_req_leaf;
    w_req_valid_nxt   = r_req_valid;
    w_finished_nxt    = r_finished;

    if (w_resp_hit) w_pending_nxt[i_resp_leaf] = 1'b0;
    if (w_hs)       w_pending_nxt[r_req_leaf]  = 1'b1;

    case ({w_hs, w_resp_hit})
      2'b10:   w_outstanding_nxt = r_outstanding + CNT_W'(1);
      2'b01:   w_outstanding_nxt = r_outstanding - CNT_W'(1);
      default: w_outstanding_nxt = r_outstanding;
    endcase

    case (r_state)
      ST_IDLE: begin
        if (w_done) begin
          w_state_nxt    = ST_FINISHED;
          w_finished_nxt = 1'b1;
        end else if (w_win_found && w_cap_ok) begin
          w_state_nxt     = ST_ISSUE;
          w_req_valid_nxt = 1'b1;
          w_req_leaf_nxt  = w_win_idx;
        end
      end
      ST_ISSUE: begin
        if (w_hs) begin
          w_state_nxt     = ST_IDLE;
          w_req_valid_nxt = 1'b0;
          w_rr_ptr_nxt    = r_req_leaf + LEAF_W'(1);
        end
      end
      ST_FINISHED: begin
        w_req_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_req_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_pending     <= '0;
      r_outstanding <= '0;
      r_rr_ptr      <= '0;
      r_req_leaf    <= '0;
      r_req_valid   <= 1'b0;
      r_finished    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pending     <= w_pending_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_req_leaf    <= w_req_leaf_nxt;
      r_req_valid   <= w_req_valid_nxt;
      r_finished    <= w_finished_nxt;
    end
  end

  assign o_req_valid = r_req_valid;
  assign o_req_leaf  = r_req_leaf;
  assign o_req_len   = LEN_W'(BURST_LEN);
  assign o_pending   = r_pending;
  assign o_finished  = r_finished;

endmodule
